// File: rtl/novacore_cfg_pkg.sv
// Shared types and constants for the NovaCORE configuration loader.
// Beat layout is {dim, uid, payload} with dim in the MSBs.
package novacore_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SWITCH,
        S_SETUP,
        S_CLKHI,
        S_HOLD,
        S_FINISH
    } cfg_state_e;

    localparam logic MODE_CFG = 1'b0;
    localparam logic MODE_RUN = 1'b1;

    localparam int DEF_BUS_W = 74;
    localparam int DEF_UID_W = 9;
    localparam int UID_LSB   = DEF_BUS_W;
    localparam int DIM_LSB   = DEF_UID_W + DEF_BUS_W;

    // Offsets for non-default widths.
    function automatic int uid_lsb(input int bus_w);
        return bus_w;
    endfunction

    function automatic int dim_lsb(input int uid_w, input int bus_w);
        return uid_w + bus_w;
    endfunction

endpackage

// File: rtl/novacore_cfg_strobe.sv
// c_clk generator: on go, runs SETUP (low), HIGH (high), HOLD (low) phases
// off one shared down-counter; adv marks each phase end, fin the HOLD end.
module novacore_cfg_strobe #(
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic adv,
    output logic fin,
    output logic c_clk
);

    localparam int MAXC = (SETUP_CYC > HIGH_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((HIGH_CYC > HOLD_CYC) ? HIGH_CYC : HOLD_CYC);
    localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);

    typedef enum logic [1:0] {P_IDLE, P_SETUP, P_HI, P_HOLD} phase_e;

    phase_e        ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_clk_q, c_clk_d;
    logic          cnt_zero;

    assign cnt_zero = (cnt_q == '0);
    assign adv      = (ph_q != P_IDLE) && cnt_zero;
    assign fin      = (ph_q == P_HOLD) && cnt_zero;
    assign c_clk    = c_clk_q;

    always_comb begin
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        c_clk_d = c_clk_q;
        case (ph_q)
            P_IDLE: if (go) begin
                ph_d    = P_SETUP;
                cnt_d   = CW'(SETUP_CYC - 1);
                c_clk_d = 1'b0;
            end
            P_SETUP: if (cnt_zero) begin
                ph_d    = P_HI;
                cnt_d   = CW'(HIGH_CYC - 1);
                c_clk_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            P_HI: if (cnt_zero) begin
                ph_d    = P_HOLD;
                cnt_d   = CW'(HOLD_CYC - 1);
                c_clk_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            P_HOLD: if (cnt_zero) begin
                ph_d = P_IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            default: ph_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q    <= P_IDLE;
            cnt_q   <= '0;
            c_clk_q <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            c_clk_q <= c_clk_d;
        end
    end

endmodule

// File: rtl/novacore_cfg_loader.sv
// NovaCORE configuration sequencer: takes host beats over valid/ready, drives
// the fabric config port with strobed writes, then releases the fabric to run.
module novacore_cfg_loader
    import novacore_cfg_pkg::*;
#(
    parameter int BUS_W     = 74,
    parameter int UID_W     = 9,
    parameter int DIM_W     = 2,
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DIM_W+UID_W+BUS_W-1:0] s_data,
    input  logic                         s_last,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             cfg_count,
    output logic                         mode,
    output logic [BUS_W-1:0]             c_bus,
    output logic [UID_W-1:0]             c_uid,
    output logic                         c_clk,
    output logic [DIM_W-1:0]             c_dimension,
    output logic                         c_dimswitch
);

    localparam int U_LSB = uid_lsb(BUS_W);
    localparam int D_LSB = dim_lsb(UID_W, BUS_W);

    cfg_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic             s_ready_q, s_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_q, last_d;
    logic             dsw_q, dsw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic [UID_W-1:0] uid_q, uid_d;
    logic [DIM_W-1:0] dim_q, dim_d;

    logic             hs, go, adv, fin;
    logic [DIM_W-1:0] beat_dim;

    assign hs       = s_ready_q && s_valid;
    assign beat_dim = s_data[D_LSB +: DIM_W];

    novacore_cfg_strobe #(
        .SETUP_CYC (SETUP_CYC),
        .HIGH_CYC  (HIGH_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .adv   (adv),
        .fin   (fin),
        .c_clk (c_clk)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        last_d  = last_q;
        dsw_d   = 1'b0;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        uid_d   = uid_q;
        dim_d   = dim_q;
        go      = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD;
                mode_d  = MODE_CFG;
                cnt_d   = '0;
            end
            S_LOAD: if (hs) begin
                bus_d  = s_data[BUS_W-1:0];
                uid_d  = s_data[U_LSB +: UID_W];
                last_d = s_last;
                if (beat_dim != dim_q) begin
                    state_d = S_SWITCH;
                    dim_d   = beat_dim;
                    dsw_d   = 1'b1;
                end else begin
                    state_d = S_SETUP;
                    go      = 1'b1;
                end
            end
            S_SWITCH: begin
                state_d = S_SETUP;
                go      = 1'b1;
            end
            S_SETUP: if (adv) state_d = S_CLKHI;
            S_CLKHI: if (adv) state_d = S_HOLD;
            S_HOLD: if (fin) begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (last_q) begin
                    state_d = S_FINISH;
                    mode_d  = MODE_RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        s_ready_d = (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_CFG;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            last_q    <= 1'b0;
            dsw_q     <= 1'b0;
            cnt_q     <= '0;
            bus_q     <= '0;
            uid_q     <= '0;
            dim_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            last_q    <= last_d;
            dsw_q     <= dsw_d;
            cnt_q     <= cnt_d;
            bus_q     <= bus_d;
            uid_q     <= uid_d;
            dim_q     <= dim_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_count   = cnt_q;
    assign mode        = mode_q;
    assign c_bus       = bus_q;
    assign c_uid       = uid_q;
    assign c_dimension = dim_q;
    assign c_dimswitch = dsw_q;

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Scoreboard bench for the config loader: accepted beats are queued and
// matched against c_bus/c_uid/c_dimension on each c_clk rising edge.
module tb_novacore_cfg_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default-timing instance
    logic        start, s_valid, s_last, s_ready, busy, done, mode, c_clk, c_dimswitch;
    logic [84:0] s_data;
    logic [15:0] cfg_count;
    logic [73:0] c_bus;
    logic [8:0]  c_uid;
    logic [1:0]  c_dimension;

    // stretched-timing, narrow-counter instance
    logic        start2, s_valid2, s_last2, s_ready2, busy2, done2, mode2, c_clk2, c_dimswitch2;
    logic [84:0] s_data2;
    logic [1:0]  cfg_count2;
    logic [73:0] c_bus2;
    logic [8:0]  c_uid2;
    logic [1:0]  c_dimension2;

    novacore_cfg_loader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .busy(busy), .done(done), .cfg_count(cfg_count),
        .mode(mode), .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk),
        .c_dimension(c_dimension), .c_dimswitch(c_dimswitch)
    );

    novacore_cfg_loader #(.SETUP_CYC(3), .HIGH_CYC(1), .HOLD_CYC(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_data(s_data2), .s_last(s_last2), .busy(busy2), .done(done2), .cfg_count(cfg_count2),
        .mode(mode2), .c_bus(c_bus2), .c_uid(c_uid2), .c_clk(c_clk2),
        .c_dimension(c_dimension2), .c_dimswitch(c_dimswitch2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    logic [84:0] beat_q[$];
    logic [15:0] cnt_q[$];

    int   cyc = 0;
    int   acc_cyc = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   done_cyc = 0;
    int   nsw = 0;
    logic prev_clk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (c_clk && !prev_clk) begin
            rise_cyc <= cyc;
            chk("strobe_expected", beat_q.size() != 0, 1);
            if (beat_q.size() != 0) begin
                chk("c_bus", c_bus, beat_q[0][73:0]);
                chk("c_uid", c_uid, beat_q[0][82:74]);
                chk("c_dim", c_dimension, beat_q[0][84:83]);
                void'(beat_q.pop_front());
            end
        end
        if (!c_clk && prev_clk) fall_cyc <= cyc;
        if (c_dimswitch) begin
            nsw <= nsw + 1;
            chk("dsw_vs_clk", c_clk, 0);
        end
        if (done) begin
            done_cyc <= cyc;
            chk("done_expected", cnt_q.size() != 0, 1);
            if (cnt_q.size() != 0) chk("cfg_count", cfg_count, cnt_q.pop_front());
            chk("mode_run", mode, 1);
        end
        prev_clk <= c_clk;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] d, input logic [8:0] u,
                             input logic [73:0] p, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = {d, u, p};
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", n < 60, 1);
        if (n < 60) begin
            acc_cyc = cyc;
            beat_q.push_back({d, u, p});
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", n < 80, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [73:0] p;
        int sw0, n, nb;
        int acc2[4];
        logic wave[0:127];
        logic saw_done2;
        logic [1:0] cnt2_at_done;

        start = 0; s_valid = 0; s_last = 0; s_data = '0;
        start2 = 0; s_valid2 = 0; s_last2 = 0; s_data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {s_ready, busy, done, mode, c_clk, c_dimswitch}, 0);
        chk("rst_cnt", cfg_count, 0);
        chk("rst_bus", {c_dimension, c_uid, c_bus}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // beats offered in IDLE are ignored
        s_valid = 1'b1;
        s_data  = {2'd1, 9'h0ff, 74'h3};
        repeat (5) @(negedge clk);
        chk("idle_ready", s_ready, 0);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;

        // single beat timing
        pulse_start();
        cnt_q.push_back(16'd1);
        send_beat(2'd0, 9'h005, 74'h1, 1'b1);
        wait_done();
        chk("t1_rise", rise_cyc - acc_cyc, 2);
        chk("t1_high", fall_cyc - rise_cyc, 2);
        chk("t1_done", done_cyc - acc_cyc, 5);
        chk("t1_nosw", nsw, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mode_hold", mode, 1);
        chk("idle_after_done", busy, 0);

        // three beats with one dimension switch, plus start while busy
        pulse_start();
        chk("t2_mode_cfg", mode, 0);
        cnt_q.push_back(16'd3);
        sw0 = nsw;
        send_beat(2'd0, 9'h011, 74'h2aa, 1'b0);
        send_beat(2'd2, 9'h022, 74'h155, 1'b0);
        chk("t2_dim", c_dimension, 2);
        pulse_start();
        send_beat(2'd2, 9'h044, 74'h3ff0, 1'b1);
        wait_done();
        chk("t2_nsw", nsw - sw0, 1);

        // host throttling between beats
        pulse_start();
        cnt_q.push_back(16'd2);
        p = {10'($urandom()), $urandom(), $urandom()};
        send_beat(2'd1, 9'h1aa, p, 1'b0);
        repeat (7) @(negedge clk);
        chk("t3_wait_ready", s_ready, 1);
        chk("t3_wait_clk", c_clk, 0);
        chk("t3_wait_bus", c_bus, p);
        chk("t3_wait_busy", busy, 1);
        @(posedge clk); #1;
        send_beat(2'd1, 9'h100, ~p, 1'b1);
        wait_done();

        // reset during CLKHI, then a fresh two-beat session
        pulse_start();
        send_beat(2'd3, 9'h0c3, 74'h77, 1'b0);
        n = 0;
        while (!c_clk && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_hi_seen", c_clk, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_clk", c_clk, 0);
        chk("t4_rst_mode", mode, 0);
        chk("t4_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        cnt_q.push_back(16'd2);
        send_beat(2'd0, 9'h001, 74'h123456789, 1'b0);
        send_beat(2'd1, 9'h002, 74'h9abcdef, 1'b1);
        wait_done();

        // stretched timing and counter saturation on the second instance
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        s_valid2 = 1'b1;
        s_data2  = {2'd0, 9'h001, 74'h5};
        s_last2  = 1'b0;
        nb = 0;
        saw_done2 = 1'b0;
        cnt2_at_done = '0;
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            wave[k] = c_clk2;
            if (s_ready2 && s_valid2 && nb < 4) begin
                acc2[nb] = k;
                nb++;
            end
            if (done2) begin
                saw_done2 = 1'b1;
                cnt2_at_done = cfg_count2;
                break;
            end
            @(posedge clk); #1;
            s_last2 = (nb == 3);
            if (nb == 4) s_valid2 = 1'b0;
        end
        s_valid2 = 1'b0;
        chk("t5_beats", nb, 4);
        chk("t5_done_seen", saw_done2, 1);
        if (nb == 4) begin
            chk("t5_period", acc2[1] - acc2[0], 7);
            chk("t5_period2", acc2[3] - acc2[2], 7);
            chk("t5_wave", {wave[acc2[0]+1], wave[acc2[0]+2], wave[acc2[0]+3],
                            wave[acc2[0]+4], wave[acc2[0]+5], wave[acc2[0]+6]}, 6'b000100);
        end
        chk("t5_count_sat", cnt2_at_done, 3);

        repeat (3) @(posedge clk);
        chk("sb_beats_empty", beat_q.size(), 0);
        chk("sb_done_empty", cnt_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
